// File: rtl/fu_issue_sched_pkg.sv
// fu_issue_sched_pkg: shared types for the FU issue schedulers.
//  fu_sched_state_t : scheduler FSM state (IDLE / BUSY / DRAIN)
//  ENT_IDX_W        : RS slot index width for the default 8-entry station
package fu_issue_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fu_sched_state_t;

  localparam int NUM_ENT_DEF = 8;
  localparam int ENT_IDX_W   = $clog2(NUM_ENT_DEF);

endpackage

// File: rtl/fu_issue_sched_oldest_select.sv
// oldest_select: combinational oldest-first picker over NUM_ENT RS entries.
//  eligible  in  [NUM_ENT]        entry is valid and ready
//  rob_idx   in  [NUM_ENT][ROB_W] ROB index per entry
//  head      in  [ROB_W]          current ROB head
//  win_idx   out [IDX_W]          index of the oldest eligible entry (0 if none)
//  win_oh    out [NUM_ENT]        one-hot of win_idx, 0 if none eligible
//  any_valid out                  at least one entry eligible
// Age is the distance from the ROB head; the wrap of the ROB_W-bit subtract
// is intended (ROB depth is a power of two). Ties go to the lowest index.
module oldest_select #(
  parameter int NUM_ENT = 8,
  parameter int ROB_W   = 5,
  localparam int IDX_W  = $clog2(NUM_ENT)
) (
  input  logic [NUM_ENT-1:0]            eligible,
  input  logic [NUM_ENT-1:0][ROB_W-1:0] rob_idx,
  input  logic [ROB_W-1:0]              head,
  output logic [IDX_W-1:0]              win_idx,
  output logic [NUM_ENT-1:0]            win_oh,
  output logic                          any_valid
);

  logic [NUM_ENT-1:0][ROB_W-1:0] age;

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_age
    assign age[i] = rob_idx[i] - head;
  end

  logic [ROB_W-1:0] best_age;
  logic             found;

  // Scan upward with a strict less-than so an equal age never displaces a
  // lower-index winner.
  always_comb begin
    win_idx  = '0;
    best_age = '1;
    found    = 1'b0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (eligible[i] && (!found || (age[i] < best_age))) begin
        found    = 1'b1;
        best_age = age[i];
        win_idx  = IDX_W'(i);
      end
    end
    win_oh = '0;
    if (found) win_oh[win_idx] = 1'b1;
  end

  assign any_valid = |eligible;

endmodule

// File: rtl/fu_issue_sched.sv
// fu_issue_sched: oldest-first issue scheduler for one non-pipelined
// multi-cycle FU fed from one reservation station.
//  clk, rst_n      clock / async active-low reset
//  rs_valid        [NUM_ENT]        entry holds an instruction
//  rs_ready        [NUM_ENT]        entry operands ready
//  rs_rob_idx      [NUM_ENT*ROB_W]  ROB index per entry (entry i at bits i*ROB_W)
//  rob_head_idx    [ROB_W]          ROB head
//  flush                            pipeline flush
//  fu_wb_resp                       FU writes back this cycle
//  rs_grant        [NUM_ENT]        comb one-hot grant, RS dequeues it this cycle
//  fu_issue_valid                   registered, FU latches op
//  fu_issue_idx    [clog2(NUM_ENT)] registered RS slot of the issued op
//  fu_busy                          FSM in BUSY or DRAIN
//  wb_kill                          comb, writeback belongs to a flushed op
//  wb_timeout_err                   sticky, FU failed to write back in TIMEOUT cycles
module fu_issue_sched
  import fu_issue_sched_pkg::*;
#(
  parameter int NUM_ENT   = 8,
  parameter int ROB_W     = 5,
  parameter int BACK2BACK = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_ENT-1:0]         rs_valid,
  input  logic [NUM_ENT-1:0]         rs_ready,
  input  logic [NUM_ENT*ROB_W-1:0]   rs_rob_idx,
  input  logic [ROB_W-1:0]           rob_head_idx,
  input  logic                       flush,
  input  logic                       fu_wb_resp,
  output logic [NUM_ENT-1:0]         rs_grant,
  output logic                       fu_issue_valid,
  output logic [$clog2(NUM_ENT)-1:0] fu_issue_idx,
  output logic                       fu_busy,
  output logic                       wb_kill,
  output logic                       wb_timeout_err
);

  localparam int IDX_W = $clog2(NUM_ENT);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  fu_sched_state_t state, state_nxt;

  logic [NUM_ENT-1:0][ROB_W-1:0] rob_arr;
  logic [NUM_ENT-1:0]            eligible;
  logic [IDX_W-1:0]              win_idx;
  logic [NUM_ENT-1:0]            win_oh;
  logic                          any_valid;
  logic                          can_issue;
  logic [TMR_W-1:0]              timer, timer_nxt;

  assign rob_arr  = rs_rob_idx;
  assign eligible = rs_valid & rs_ready;

  oldest_select #(.NUM_ENT(NUM_ENT), .ROB_W(ROB_W)) u_sel (
    .eligible  (eligible),
    .rob_idx   (rob_arr),
    .head      (rob_head_idx),
    .win_idx   (win_idx),
    .win_oh    (win_oh),
    .any_valid (any_valid)
  );

  // rst_n gates the grant so the RS sees no dequeue while reset is held,
  // even though IDLE would otherwise allow issue.
  assign can_issue = rst_n & ~flush & any_valid &
                     ((state == IDLE) |
                      ((state == BUSY) & fu_wb_resp & (BACK2BACK != 0)));

  assign rs_grant = can_issue ? win_oh : '0;
  assign wb_kill  = (state == DRAIN) & fu_wb_resp;
  assign fu_busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (can_issue) state_nxt = BUSY;
      BUSY: begin
        // flush together with wb: the op completed before the flush took
        // effect, so nothing is left to drain.
        if (flush && !fu_wb_resp) state_nxt = DRAIN;
        else if (fu_wb_resp)      state_nxt = can_issue ? BUSY : IDLE;
      end
      DRAIN: if (fu_wb_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    timer_nxt = timer;
    if (fu_wb_resp || ((state_nxt != state) && (state_nxt != IDLE)))
      timer_nxt = '0;
    else if ((state != IDLE) && (timer != TMR_W'(TIMEOUT)))
      timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      timer          <= '0;
      fu_issue_valid <= 1'b0;
      fu_issue_idx   <= '0;
      wb_timeout_err <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      fu_issue_valid <= can_issue;
      if (can_issue) fu_issue_idx <= win_idx;
      // Error fires on the edge the timer reaches TIMEOUT; the saturated
      // value can only have been reached while waiting on the FU.
      if ((state != IDLE) && (timer_nxt == TMR_W'(TIMEOUT)))
        wb_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_issue_sched.sv
module tb_fu_issue_sched;

  localparam int NE = 8;
  localparam int RW = 5;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NE-1:0]   rs_valid = '0;
  logic [NE-1:0]   rs_ready = '0;
  logic [NE-1:0][RW-1:0] rob = '0;
  logic [RW-1:0]   head = '0;
  logic            flush = 1'b0;
  logic            wb = 1'b0;

  logic [NE-1:0] a_grant, b_grant;
  logic          a_iv, b_iv, a_busy, b_busy, a_kill, b_kill, a_err, b_err;
  logic [2:0]    a_idx, b_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_issue_sched #(.NUM_ENT(NE), .ROB_W(RW), .BACK2BACK(1), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_rob_idx(rob), .rob_head_idx(head), .flush(flush), .fu_wb_resp(wb),
    .rs_grant(a_grant), .fu_issue_valid(a_iv), .fu_issue_idx(a_idx),
    .fu_busy(a_busy), .wb_kill(a_kill), .wb_timeout_err(a_err));

  fu_issue_sched #(.NUM_ENT(NE), .ROB_W(RW), .BACK2BACK(0), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_rob_idx(rob), .rob_head_idx(head), .flush(flush), .fu_wb_resp(wb),
    .rs_grant(b_grant), .fu_issue_valid(b_iv), .fu_issue_idx(b_idx),
    .fu_busy(b_busy), .wb_kill(b_kill), .wb_timeout_err(b_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    rs_valid = '0; rs_ready = '0; rob = '0; head = '0; flush = 1'b0; wb = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clr_in();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Present one ready entry and let both DUTs issue it.
  task automatic issue_one(input int e);
    clr_in();
    rs_valid[e] = 1'b1; rs_ready[e] = 1'b1;
    step();
    clr_in();
    #1;
  endtask

  initial begin
    // 1 reset with everything eligible
    rst_n = 1'b0;
    rs_valid = '1; rs_ready = '1;
    #2;
    chk("rst_grant", a_grant, 8'h00);
    step();
    chk("rst_iv", a_iv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_err", a_err, 0);
    clr_in();
    rst_n = 1'b1;
    #1;

    // 2 age wrap: head 30, ent2 rob 1 (age 3), ent5 rob 31 (age 1);
    //   ent0 rob 30 (age 0) is valid but not ready
    head = 5'd30;
    rob[2] = 5'd1; rob[5] = 5'd31; rob[0] = 5'd30;
    rs_valid = 8'b0010_0101; rs_ready = 8'b0010_0100;
    #1;
    chk("wrap_grant", a_grant, 8'b0010_0000);
    step();
    chk("wrap_iv", a_iv, 1);
    chk("wrap_idx", a_idx, 5);
    chk("wrap_busy", a_busy, 1);
    rs_valid[5] = 1'b0;
    #1;
    chk("busy_nogrant", a_grant, 8'h00);
    step();
    chk("busy_iv0", a_iv, 0);
    chk("busy_idx_hold", a_idx, 5);

    // 3 back-to-back: both BUSY; wb arrives with ent0 ready
    clr_in();
    rs_valid[0] = 1'b1; rs_ready[0] = 1'b1; rob[0] = 5'd2;
    wb = 1'b1;
    #1;
    chk("b2b_grant_a", a_grant, 8'h01);
    chk("b2b_grant_b", b_grant, 8'h00);
    chk("b2b_kill", a_kill, 0);
    step();
    wb = 1'b0;
    #1;
    chk("b2b_busy_a", a_busy, 1);
    chk("b2b_iv_a", a_iv, 1);
    chk("b2b_idx_a", a_idx, 0);
    chk("nob2b_busy_b", b_busy, 0);
    chk("nob2b_iv_b", b_iv, 0);
    chk("nob2b_grant_b", b_grant, 8'h01);
    chk("b2b_a_nogrant", a_grant, 8'h00);
    step();
    chk("nob2b_iv_b2", b_iv, 1);
    chk("nob2b_busy_b2", b_busy, 1);

    // tie: ent3 and ent6 both age 7 -> lowest index
    do_reset();
    rob[3] = 5'd7; rob[6] = 5'd7;
    rs_valid = 8'b0100_1000; rs_ready = 8'b0100_1000;
    #1;
    chk("tie_grant", a_grant, 8'b0000_1000);

    // 4 flush in flight -> DRAIN, wb three cycles later is killed
    do_reset();
    issue_one(1);
    chk("fl_busy", a_busy, 1);
    rs_valid[4] = 1'b1; rs_ready[4] = 1'b1; rob[4] = 5'd9;
    flush = 1'b1;
    #1;
    chk("fl_grant", a_grant, 8'h00);
    step();
    flush = 1'b0;
    #1;
    chk("drain_busy", a_busy, 1);
    chk("drain_grant1", a_grant, 8'h00);
    step();
    chk("drain_grant2", a_grant, 8'h00);
    step();
    wb = 1'b1;
    #1;
    chk("drain_kill", a_kill, 1);
    chk("drain_grant3", a_grant, 8'h00);
    step();
    wb = 1'b0;
    #1;
    chk("drain_idle", a_busy, 0);
    chk("drain_iv", a_iv, 0);
    chk("idle_grant", a_grant, 8'b0001_0000);
    chk("idle_kill", a_kill, 0);

    // 5 flush and wb together in BUSY
    do_reset();
    issue_one(0);
    rs_valid[3] = 1'b1; rs_ready[3] = 1'b1; rob[3] = 5'd4;
    flush = 1'b1; wb = 1'b1;
    #1;
    chk("fw_kill", a_kill, 0);
    chk("fw_grant", a_grant, 8'h00);
    step();
    flush = 1'b0; wb = 1'b0;
    #1;
    chk("fw_idle", a_busy, 0);
    chk("fw_grant_next", a_grant, 8'b0000_1000);

    // 6 timeout after 15 cycles with no writeback
    do_reset();
    issue_one(0);
    repeat (TO - 1) step();
    chk("to_err_early", a_err, 0);
    step();
    chk("to_err", a_err, 1);
    chk("to_busy", a_busy, 1);
    wb = 1'b1;
    step();
    wb = 1'b0;
    #1;
    chk("to_wb_idle", a_busy, 0);
    chk("to_sticky", a_err, 1);
    wb = 1'b1;
    #1;
    chk("stray_kill", a_kill, 0);
    step();
    wb = 1'b0;
    #1;
    chk("stray_idle", a_busy, 0);
    chk("stray_sticky", a_err, 1);
    do_reset();
    chk("err_reset", a_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
